playback_multichannel: RTL and testbench
========================================

PLAYBACK_MULTICHANNEL -- requirements
Module: playback_multichannel

Interface
REQ-001 Parameter CHANNELS, default 4: number of simultaneous phrase channels (1-8).
REQ-002 Parameter PHRASE_LEN, default 16: lines per phrase (power of two, 2-256); AW = log2(PHRASE_LEN).
REQ-003 Parameter CLK_FREQ, default 100_000_000: clk frequency in Hz.
REQ-004 Parameter ACC_WIDTH, default 48: tempo phase accumulator width.
REQ-005 Ports, in order:
- clk  in  1  system clock, all logic on rising edge.
- reset_active_high  in  1  asynchronous, active-high reset.
- tempo  in  9  bpm, 0-511; one phrase line per beat.
- play_enable  in  1  level; high = play, low = pause.
- loop_enable  in  1  level; wrap at end of phrase.
- restart  in  1  single-cycle pulse; return to line 0.
- entry_rd_addr  out  AW  phrase memory line address.
- entry_rd_data  in  16*CHANNELS  per channel {note[15:8], volume[7:2], instrument[1:0]}; channel c at bits [16c+15:16c]; valid exactly 1 cycle after entry_rd_addr.
- line_count  out  AW  current playhead line.
- freq_word  out  32*CHANNELS  DDS tuning word per channel.
- volume  out  6*CHANNELS  per-channel volume.
- instrument  out  2*CHANNELS  per-channel synth select.
- gate  out  CHANNELS  per-channel note-on.
- step_pulse  out  1  one-cycle strobe when new line outputs become visible.
- done  out  1  high while in DONE.

Function
REQ-006 States SHALL be IDLE, FETCH, LATCH, RUN, PAUSED, DONE.
REQ-007 inc SHALL be a register loaded every cycle with floor(tempo * 2^ACC_WIDTH / (CLK_FREQ*60)); a tempo change takes effect 1 cycle later, with no acc reset and no glitch.
REQ-008 In RUN, FETCH and LATCH, acc <= acc + inc (mod 2^ACC_WIDTH). tick SHALL be the carry out of that addition. In all other states, and whenever tempo = 0, acc SHALL hold and tick SHALL be 0.
REQ-009 IDLE: line_count = 0, acc = 0. When play_enable = 1, go to FETCH.
REQ-010 FETCH: drive entry_rd_addr = line_count for one cycle, then go to LATCH.
REQ-011 LATCH: register every channel's fields from entry_rd_data, then go to RUN. The new outputs and step_pulse SHALL appear the cycle after LATCH.
REQ-012 RUN on tick with line_count < PHRASE_LEN-1: line_count +1, go to FETCH.
REQ-013 RUN on tick with line_count = PHRASE_LEN-1:
- loop_enable = 1: line_count <= 0, go to FETCH.
- loop_enable = 0: go to DONE; line_count holds.
REQ-014 Latency: tick in cycle T -> line_count and entry_rd_addr change at T+1 -> data valid at T+2 -> outputs and step_pulse visible at T+3.
REQ-015 Note decode: for note n <= 0x6B, freq_word = BASE[n mod 12] >> (8 - n/12), where BASE = 179712, 190464, 201728, 213760, 226560, 240128, 254208, 269312, 285440, 302336, 320512, 339456; gate = 1.
REQ-016 Note n >= 0x6C (0xFF = rest) SHALL set gate = 0 and hold that channel's previous freq_word; volume and instrument still update.
REQ-017 play_enable low in RUN, FETCH or LATCH: go to PAUSED next cycle, discarding any in-flight fetch.
REQ-018 PAUSED: all gates 0, acc and line_count held, other outputs held. When play_enable returns high, go to FETCH and refetch the current line without advancing.
REQ-019 DONE: done = 1, gates 0. When play_enable is low, go to IDLE; otherwise stay.
REQ-020 restart in any non-IDLE state: line_count <= 0, acc <= 0, then go to FETCH if play_enable = 1, else IDLE.
REQ-021 Priority: reset > restart > play_enable low > tick.
REQ-022 loop_enable SHALL be sampled only on the end-of-phrase tick.

Reset
REQ-023 While reset_active_high is high: state = IDLE, acc = 0, inc = 0, line_count = 0, entry_rd_addr = 0, freq_word = 0, volume = 0, instrument = 0, gate = 0, step_pulse = 0, done = 0.
REQ-024 Reset asserted mid-fetch or mid-phrase SHALL abandon the operation; after release, playback starts from line 0 only once play_enable = 1.

Verification
REQ-025 CLK_FREQ = 600, PHRASE_LEN = 16, tempo = 120, play_enable held high -> step_pulse spacing is 300 or 301 cycles, and line_count runs 0..15.
REQ-026 loop_enable = 0 over a full phrase -> done = 1 after line 15 expires and all gates = 0; drop play_enable -> IDLE with line_count = 0.
REQ-027 loop_enable = 1 -> line 0 is refetched after line 15, done never asserts, and the line 15 -> 0 step has the same tick spacing as other steps.
REQ-028 Note decode per channel:
- note 0x00 -> freq_word = 702.
- note 0x39 -> 18896.
- note 0x6B -> 339456.
- note 0xFF -> gate = 0 with previous freq_word held.
- note 0x70 -> gate = 0.
REQ-029 Pause at line 5 for 1000 cycles -> gates = 0 and line_count = 5 throughout; on resume, line 5 is refetched, step_pulse fires 3 cycles after play_enable rises, and the remaining beat time is preserved.
REQ-030 Stimulus:
- restart pulse coincident with a tick -> line_count = 0 and no advance.
- reset asserted during LATCH -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/playback_multichannel.sv
// Tempo-driven phrase playhead: fetches one phrase line per beat and decodes each
// channel's note into a DDS tuning word with gate, volume and instrument.
module playback_multichannel #(
  parameter int CHANNELS   = 4,
  parameter int PHRASE_LEN = 16,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int ACC_WIDTH  = 48,
  localparam int AW = $clog2(PHRASE_LEN)
) (
  input  logic                   clk,
  input  logic                   reset_active_high,
  input  logic [8:0]             tempo,
  input  logic                   play_enable,
  input  logic                   loop_enable,
  input  logic                   restart,
  output logic [AW-1:0]          entry_rd_addr,
  input  logic [16*CHANNELS-1:0] entry_rd_data,
  output logic [AW-1:0]          line_count,
  output logic [32*CHANNELS-1:0] freq_word,
  output logic [6*CHANNELS-1:0]  volume,
  output logic [2*CHANNELS-1:0]  instrument,
  output logic [CHANNELS-1:0]    gate,
  output logic                   step_pulse,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, RUN, PAUSED, DONE} state_e;

  localparam int              NW   = ACC_WIDTH + 9;
  localparam logic [NW-1:0]   DIV  = NW'(64'(CLK_FREQ) * 64'd60);
  localparam logic [AW-1:0]   LAST = AW'(PHRASE_LEN - 1);
  localparam logic [18:0]     BASE [12] = '{19'd179712, 19'd190464, 19'd201728, 19'd213760,
                                            19'd226560, 19'd240128, 19'd254208, 19'd269312,
                                            19'd285440, 19'd302336, 19'd320512, 19'd339456};

  function automatic logic [31:0] note_freq(input logic [7:0] n);
    logic [3:0] oct, semi;
    oct  = 4'(n / 8'd12);
    semi = 4'(n % 8'd12);
    return 32'(BASE[semi] >> (4'd8 - oct));
  endfunction

  state_e                       state_q;
  logic [ACC_WIDTH-1:0]         acc_q, inc_q, inc_d;
  logic [ACC_WIDTH:0]           sum;
  logic [AW-1:0]                line_q;
  logic                         pend_q, step_q, done_q, adv, tick;
  logic [CHANNELS-1:0][31:0]    freq_q, freq_w;
  logic [CHANNELS-1:0][5:0]     vol_q;
  logic [CHANNELS-1:0][1:0]     inst_q;
  logic [CHANNELS-1:0][7:0]     note_w;
  logic [CHANNELS-1:0]          gate_q, rest_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign note_w[g] = entry_rd_data[16*g+8 +: 8];
    assign rest_w[g] = note_w[g] > 8'h6B;
    assign freq_w[g] = note_freq(note_w[g]);
  end

  assign inc_d = ACC_WIDTH'({tempo, {ACC_WIDTH{1'b0}}} / DIV);
  assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
  assign adv   = (state_q inside {FETCH, LATCH, RUN}) && (tempo != 9'd0);
  assign tick  = adv && sum[ACC_WIDTH];

  // A beat boundary that lands in FETCH/LATCH or in the pause cycle is remembered in
  // pend_q so no beat is lost around a refetch.
  always_ff @(posedge clk or posedge reset_active_high) begin
    if (reset_active_high) begin
      state_q <= IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      line_q  <= '0;
      pend_q  <= 1'b0;
      freq_q  <= '0;
      vol_q   <= '0;
      inst_q  <= '0;
      gate_q  <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      inc_q  <= inc_d;
      step_q <= 1'b0;
      if (restart && state_q != IDLE) begin
        line_q <= '0;
        acc_q  <= '0;
        pend_q <= 1'b0;
        done_q <= 1'b0;
        if (play_enable) state_q <= FETCH;
        else begin
          state_q <= IDLE;
          gate_q  <= '0;
        end
      end else begin
        if (adv) acc_q <= sum[ACC_WIDTH-1:0];
        case (state_q)
          IDLE: begin
            line_q <= '0;
            acc_q  <= '0;
            pend_q <= 1'b0;
            if (play_enable) state_q <= FETCH;
          end
          FETCH, LATCH, RUN: begin
            if (!play_enable) begin
              state_q <= PAUSED;
              gate_q  <= '0;
              pend_q  <= pend_q | tick;
            end else if (state_q == FETCH) begin
              state_q <= LATCH;
              pend_q  <= pend_q | tick;
            end else if (state_q == LATCH) begin
              state_q <= RUN;
              pend_q  <= pend_q | tick;
              step_q  <= 1'b1;
              for (int c = 0; c < CHANNELS; c++) begin
                vol_q[c]  <= entry_rd_data[16*c+2 +: 6];
                inst_q[c] <= entry_rd_data[16*c +: 2];
                gate_q[c] <= !rest_w[c];
                if (!rest_w[c]) freq_q[c] <= freq_w[c];
              end
            end else if (tick || pend_q) begin
              pend_q <= 1'b0;
              if (line_q != LAST) begin
                line_q  <= line_q + AW'(1);
                state_q <= FETCH;
              end else if (loop_enable) begin
                line_q  <= '0;
                state_q <= FETCH;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
                gate_q  <= '0;
              end
            end
          end
          PAUSED: if (play_enable) state_q <= FETCH;
          DONE: if (!play_enable) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            line_q  <= '0;
            acc_q   <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign entry_rd_addr = line_q;
  assign line_count    = line_q;
  assign freq_word     = freq_q;
  assign volume        = vol_q;
  assign instrument    = inst_q;
  assign gate          = gate_q;
  assign step_pulse    = step_q;
  assign done          = done_q;
endmodule

// File: tb/tb_playback_multichannel.sv
// Directed/random bench for playback_multichannel at CLK_FREQ=600, tempo 120 (300-cycle beats).
module tb_playback_multichannel;
  localparam int CH = 4, PL = 16;

  logic            clk = 1'b0, rst = 1'b1;
  logic [8:0]      tempo = 9'd120;
  logic            play = 1'b0, loop_en = 1'b0, restart = 1'b0;
  logic [3:0]      rd_addr, line;
  logic [16*CH-1:0] rd_data = '0;
  logic [32*CH-1:0] freq;
  logic [6*CH-1:0]  vol;
  logic [2*CH-1:0]  inst;
  logic [CH-1:0]    gate;
  logic             step, done;

  int total = 0, bad = 0;
  logic [15:0] mem [PL][CH];
  logic [31:0] mf [CH];
  int base_t [12] = '{179712, 190464, 201728, 213760, 226560, 240128,
                      254208, 269312, 285440, 302336, 320512, 339456};
  longint unsigned inc_m, k1, k2;

  playback_multichannel #(.CHANNELS(CH), .PHRASE_LEN(PL), .CLK_FREQ(600), .ACC_WIDTH(48)) dut (
    .clk(clk), .reset_active_high(rst), .tempo(tempo), .play_enable(play),
    .loop_enable(loop_en), .restart(restart), .entry_rd_addr(rd_addr),
    .entry_rd_data(rd_data), .line_count(line), .freq_word(freq), .volume(vol),
    .instrument(inst), .gate(gate), .step_pulse(step), .done(done));

  always #5 clk = ~clk;

  // phrase memory with one cycle read latency
  always @(posedge clk)
    for (int c = 0; c < CH; c++) rd_data[16*c +: 16] <= mem[rd_addr][c];

  function automatic int dec(input int n);
    return base_t[n % 12] / (1 << (8 - n / 12));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input bit directed);
    for (int l = 0; l < PL; l++)
      for (int c = 0; c < CH; c++) begin
        int r;
        logic [7:0] n;
        r = $urandom_range(0, 9);
        if (r < 7)       n = 8'($urandom_range(0, 107));
        else if (r == 7) n = 8'hFF;
        else             n = 8'($urandom_range(108, 254));
        mem[l][c] = {n, 8'($urandom)};
      end
    if (directed) begin
      mem[0][0][15:8] = 8'h00;
      mem[0][1][15:8] = 8'h39;
      mem[0][2][15:8] = 8'h6B;
      mem[0][3][15:8] = 8'hFF;
      mem[1][3][15:8] = 8'h20;
      mem[2][3][15:8] = 8'hFF;
      mem[3][3][15:8] = 8'h70;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mf[c] = '0;
  endtask

  task automatic check_line(input int L);
    logic [32*CH-1:0] ef;
    logic [6*CH-1:0]  ev;
    logic [2*CH-1:0]  ei;
    logic [CH-1:0]    eg;
    for (int c = 0; c < CH; c++) begin
      int n;
      n = int'(mem[L][c][15:8]);
      eg[c] = (n <= 107);
      if (n <= 107) mf[c] = 32'(dec(n));
      ef[32*c +: 32] = mf[c];
      ev[6*c +: 6]   = mem[L][c][7:2];
      ei[2*c +: 2]   = mem[L][c][1:0];
    end
    chk($sformatf("line_L%0d", L), line, L);
    chk($sformatf("freq_L%0d", L), freq, ef);
    chk($sformatf("vol_L%0d", L), vol, ev);
    chk($sformatf("inst_L%0d", L), inst, ei);
    chk($sformatf("gate_L%0d", L), gate, eg);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_line"}, line, 0);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_freq"}, freq, 0);
    chk({tag, "_vol"}, vol, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_gate"}, gate, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic wait_step(input int budget, output int el);
    el = 0;
    do begin
      @(negedge clk);
      el++;
    end while (!step && el < budget);
    chk("step_seen", step, 1'b1);
  endtask

  initial begin
    int el, el2;
    fill_mem(1'b1);
    model_reset();
    inc_m = (64'd120 << 48) / 64'd36000;
    k1 = ((64'd1 << 48) + inc_m - 1) / inc_m;
    k2 = ((64'd2 << 48) + inc_m - 1) / inc_m;

    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_line", line, 0);
    chk("idle_step", step, 0);

    // single pass, no loop
    play = 1'b1;
    wait_step(10, el);
    chk("first_lat", el, 3);
    check_line(0);
    chk("dec_00", freq[31:0], 702);
    chk("dec_39", freq[63:32], 18896);
    chk("dec_6B", freq[95:64], 339456);
    chk("rest_gate0", gate[3], 0);
    for (int L = 1; L < PL; L++) begin
      wait_step(400, el);
      chk($sformatf("spacing_L%0d_el%0d", L, el), (el == 300 || el == 301), 1);
      check_line(L);
      if (L == 2) chk("rest_hold", freq[127:96], 4460);
      if (L == 3) begin
        chk("hi_gate", gate[3], 0);
        chk("hi_hold", freq[127:96], 4460);
      end
    end
    el = 0;
    while (!done && el < 400) begin
      @(negedge clk);
      el++;
    end
    chk("done", done, 1);
    chk("done_gate", gate, 0);
    chk("done_line", line, 15);
    repeat (50) @(negedge clk);
    chk("done_stay", done, 1);
    play = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_line0", line, 0);

    // looping playback
    fill_mem(1'b0);
    loop_en = 1'b1;
    play = 1'b1;
    wait_step(10, el);
    chk("loop_first", el, 3);
    check_line(0);
    for (int s = 1; s <= 20; s++) begin
      wait_step(400, el);
      chk($sformatf("loop_spacing_s%0d_el%0d", s, el), (el == 300 || el == 301), 1);
      check_line(s % PL);
      chk("no_done", done, 0);
    end

    // pause at line 5
    wait_step(400, el);
    check_line(5);
    repeat (100) @(negedge clk);
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(negedge clk);
      chk($sformatf("pause_gate_%0d", i), gate, 0);
      chk($sformatf("pause_line_%0d", i), line, 5);
    end
    play = 1'b1;
    wait_step(10, el);
    chk("resume_lat", el, 3);
    check_line(5);
    wait_step(400, el2);
    chk($sformatf("beat_kept_el%0d", el2), (el2 + 103 == 300 || el2 + 103 == 301), 1);
    check_line(6);

    // restart, then a second restart exactly on the second beat's tick
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_line0", line, 0);
    repeat (int'(k2) - 1) @(negedge clk);
    chk("rs_line1", line, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_tick_line", line, 0);
    repeat (2) @(negedge clk);
    chk("rs_step", step, 1);
    chk("rs_step_line", line, 0);
    repeat (int'(k1) - 3) @(negedge clk);
    chk("rs_noadv", line, 0);
    @(negedge clk);
    chk("rs_adv", line, 1);

    // reset asserted while the line-1 fetch is in LATCH
    @(negedge clk);
    play = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("rst_latch");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_line", line, 0);
    chk("post_rst_step", step, 0);
    chk("post_rst_gate", gate, 0);
    play = 1'b1;
    wait_step(10, el);
    chk("post_rst_lat", el, 3);
    check_line(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
